// File: rtl/uart_pkg.sv
// Shared types and defaults for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    localparam int unsigned DefDataW     = 8;
    localparam int unsigned DefFifoDepth = 16;
    localparam int unsigned DefClkDiv    = 16;
    localparam int unsigned DefStopBits  = 1;

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level; callers gate push and pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned DEPTH  = DefFifoDepth,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = level_w(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, empty_q;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer width equals log2(DEPTH), so increments wrap for free.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed start/data/stop serialiser with sticky overflow.
// Optional UART_TX_SIM_ECHO_EN echoes accepted words to the simulation console.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned CLK_DIV    = DefClkDiv,
    parameter int unsigned STOP_BITS  = DefStopBits,
    localparam int unsigned LW        = level_w(FIFO_DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [LW-1:0]     level,
    output logic              busy,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              tx
);

    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam int unsigned BW = $clog2(DATA_W + 1);
    localparam logic [TW-1:0] TimerMax = TW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LastData = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LastStop = BW'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, bit_end;
    logic [DATA_W-1:0] head;

    assign push = wr_en & ~full;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign bit_end = (timer_q == TimerMax);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    timer_d   = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LastData) begin
                        bit_cnt_d = '0;
                        state_d   = StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StStop: begin
                // The bit counter is reused to count stop bits.
                if (bit_end) begin
                    timer_d = '0;
                    if (bit_cnt_q == LastStop) begin
                        bit_cnt_d = '0;
                        if (!empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != StIdle);
    assign overflow = ovf_q;

`ifdef UART_TX_SIM_ECHO_EN
    always @(posedge clock) begin
        if (reset_n && push) begin
            $write("%c", wr_data);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: frame-level reference model compared every cycle, plus directed literals.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
    localparam int SB    = 1;
    localparam int FLEN  = DIV * (1 + DW + SB);

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en   = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_ovf = 1'b0;
    logic          full, empty, busy, overflow, tx;
    logic [2:0]    level;

    logic          wr_en2   = 1'b0;
    logic [6:0]    wr_data2 = '0;
    logic          full2, empty2, busy2, overflow2, tx2;
    logic [2:0]    level2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state: queued words plus the frame currently on the line.
    logic [DW-1:0] mq[$];
    bit            m_active = 1'b0;
    int            m_cyc    = 0;
    logic [DW-1:0] m_cur    = '0;
    bit            m_ovf    = 1'b0;

    always #5 clock = ~clock;

    uart_tx_fifo #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (DIV),
        .STOP_BITS  (SB)
    ) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx       (tx)
    );

    uart_tx_fifo #(
        .DATA_W     (7),
        .FIFO_DEPTH (4),
        .CLK_DIV    (4),
        .STOP_BITS  (2)
    ) u_dut2 (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_en2),
        .wr_data  (wr_data2),
        .full     (full2),
        .empty    (empty2),
        .level    (level2),
        .busy     (busy2),
        .overflow (overflow2),
        .clr_ovf  (1'b0),
        .tx       (tx2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_cyc / DIV;
        if (b == 0) return 1'b0;
        if (b <= DW) return m_cur[b-1];
        return 1'b1;
    endfunction

    initial forever begin
        bit full_prev, nonempty_prev, start;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            m_active = 1'b0;
            m_cyc    = 0;
            m_ovf    = 1'b0;
        end else begin
            full_prev     = (mq.size() == DEPTH);
            nonempty_prev = (mq.size() != 0);
            start         = 1'b0;
            if (m_active) begin
                m_cyc++;
                if (m_cyc == FLEN) begin
                    if (nonempty_prev) start = 1'b1;
                    else m_active = 1'b0;
                end
            end else if (nonempty_prev) begin
                start = 1'b1;
            end
            if (start) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_cyc    = 0;
            end
            if (wr_en && !full_prev) mq.push_back(wr_data);
            if (wr_en && full_prev) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
        end
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            check("tx", tx, exp_tx());
            check("busy", busy, m_active);
            check("level", level, mq.size());
            check("full", full, mq.size() == DEPTH);
            check("empty", empty, mq.size() == 0);
            check("overflow", overflow, m_ovf);
        end
    end

    // Called at a negedge; sends one word and samples the middle of each bit.
    task automatic send_frame(input logic [7:0] d, output logic [9:0] bits, output int busy_n);
        bits   = '0;
        busy_n = 0;
        wr_en   = 1'b1;
        wr_data = d;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock);
            if (i == 1) wr_en = 1'b0;
            if (busy) busy_n++;
            if (i >= 2 && i <= 41 && ((i - 2) % 4) == 2) bits[(i-2)/4] = tx;
        end
    endtask

    initial begin
        logic [9:0] bits;
        int         bn, lows, highs, b2;

        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_tx2", tx2, 1);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        @(negedge clock);

        send_frame(8'h55, bits, bn);
        check("frame_55", bits, 10'b1010101010);
        check("busy_len_55", bn, 40);

        wr_en = 1'b1;
        wr_data = 8'h41;
        @(negedge clock);
        wr_data = 8'h42;
        check("lvl_first_push", level, 1);
        @(negedge clock);
        wr_en = 1'b0;
        check("lvl_push_pop", level, 1);
        repeat (39) @(negedge clock);
        check("b2b_stop_tx", tx, 1);
        check("b2b_stop_lvl", level, 1);
        @(negedge clock);
        check("b2b_start_tx", tx, 0);
        check("b2b_start_lvl", level, 0);
        check("b2b_busy", busy, 1);
        repeat (60) @(negedge clock);

        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'hA0 + i);
            @(negedge clock);
            if (i == 4) begin
                check("ovf_full", full, 1);
                check("ovf_level", level, 4);
                check("ovf_before_drop", overflow, 0);
            end
        end
        check("ovf_set", overflow, 1);
        wr_data = 8'hEE;
        clr_ovf = 1'b1;
        @(negedge clock);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        check("ovf_set_wins", overflow, 1);
        repeat (5) @(negedge clock);
        check("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        @(negedge clock);
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("ovf_still_full", full, 1);
        repeat (220) @(negedge clock);

        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 99) < 5);
            wr_data = 8'($urandom);
            clr_ovf = ($urandom_range(0, 63) == 0);
            @(negedge clock);
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        repeat (250) @(negedge clock);
        check("drain_empty", empty, 1);
        check("drain_busy", busy, 0);

        lows = 0; highs = 0; b2 = 0;
        wr_en2   = 1'b1;
        wr_data2 = 7'h7F;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clock);
            if (i == 1) wr_en2 = 1'b0;
            if (busy2) b2++;
            if (i >= 2 && i <= 5 && tx2 == 1'b0) lows++;
            if (i >= 6 && i <= 41 && tx2 == 1'b1) highs++;
        end
        check("d2_start_low", lows, 4);
        check("d2_high_run", highs, 36);
        check("d2_busy_len", b2, 40);
        check("d2_idle_tx", tx2, 1);
        check("d2_empty", empty2, 1);
        check("d2_full", full2, 0);
        check("d2_level", level2, 0);
        check("d2_ovf", overflow2, 0);

        wr_en   = 1'b1;
        wr_data = 8'h33;
        @(negedge clock);
        wr_en = 1'b0;
        repeat (14) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_empty", empty, 1);
        check("midrst_level", level, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        send_frame(8'h0A, bits, bn);
        check("frame_0a", bits, 10'b1000010100);
        check("busy_len_0a", bn, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
